// File: rtl/shifter_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : shifter_right_seq
// Purpose  : Multi-cycle 32-bit logical right shifter, one log-stage per cycle.
// Revision : 1.0  initial release
// ============================================================================
module shifter_right_seq #(
  parameter logic [5:0] SRL    = 6'b000010,
  parameter int         STAGES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  stage;
  logic [4:0]  amount;
  logic [31:0] work;
  logic [31:0] work_shifted;
  logic        op_valid;
  logic        last_stage;

  assign op_valid   = (Signal == SRL) && (dataB[31:5] == 27'd0);
  assign last_stage = (stage == 3'(STAGES - 1));

  // Stage k applies a 2^k shift only when bit k of the captured amount is set.
  always_comb begin
    work_shifted = work;
    case (stage)
      3'd0: if (amount[0]) work_shifted = work >> 1;
      3'd1: if (amount[1]) work_shifted = work >> 2;
      3'd2: if (amount[2]) work_shifted = work >> 4;
      3'd3: if (amount[3]) work_shifted = work >> 8;
      3'd4: if (amount[4]) work_shifted = work >> 16;
      default: work_shifted = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op_valid ? SHIFT : DONE;
      SHIFT:   if (last_stage) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stage   <= 3'd0;
      amount  <= 5'd0;
      work    <= 32'h0;
      dataOut <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            amount <= dataB[4:0];
            stage  <= 3'd0;
            if (op_valid) work    <= dataA;
            else          dataOut <= 32'h0;
          end
        end
        SHIFT: begin
          work  <= work_shifted;
          stage <= stage + 3'd1;
          // Final stage result goes straight to the output register.
          if (last_stage) dataOut <= work_shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_shifter_right_seq.sv
`default_nettype none
// Scoreboard bench for shifter_right_seq: driver queues expected results and
// completion cycles, monitor pops them on every done pulse.
module tb_shifter_right_seq;

  localparam logic [5:0] SRL = 6'b000010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  shifter_right_seq #(.SRL(SRL), .STAGES(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          at_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hold   = 32'h0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse consumes one expectation; otherwise dataOut must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", dataOut, e.data);
          check("done_cycle", 32'(cyc), 32'(e.at_cyc));
          hold = e.data;
        end
      end else begin
        check("dataOut_hold", dataOut, hold);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one start pulse; expected value is hand-computed by the caller.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input logic [31:0] exp, input bit valid);
    exp_t e;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    e.data   = exp;
    e.at_cyc = cyc + (valid ? 6 : 1);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    dataA  = 32'hDEAD_BEEF;
    dataB  = 32'h0000_0013;
    Signal = 6'b111111;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset  = 1'b1;
    start  = 1'b0;
    dataA  = 32'h0;
    dataB  = 32'h0;
    Signal = 6'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dataOut", dataOut, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Busy window for the reference vector: busy in n+1..n+6, idle after.
    @(negedge clk);
    n0 = cyc;
    dataA = 32'h8000_0001; dataB = 32'd4; Signal = SRL; start = 1'b1;
    sb.push_back('{32'h0800_0000, n0 + 6});
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_window", 32'(busy), (i <= 6) ? 32'd1 : 32'd0);
    end

    issue(32'hFFFF_FFFF, 32'd31, SRL, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 32'd0,  SRL, 32'hFFFF_FFFF, 1'b1);
    issue(32'h8000_0000, 32'd31, SRL, 32'h0000_0001, 1'b1);
    issue(32'h1234_5678, 32'd12, SRL, 32'h0001_2345, 1'b1);
    issue(32'hA5A5_A5A5, 32'd1,  SRL, 32'h52D2_D2D2, 1'b1);
    issue(32'hDEAD_BEEF, 32'd16, SRL, 32'h0000_DEAD, 1'b1);
    issue(32'h0F0F_0F0F, 32'd7,  SRL, 32'h001E_1E1E, 1'b1);
    issue(32'h0000_0001, 32'd1,  SRL, 32'h0000_0000, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_0020, SRL, 32'h0, 1'b0);
    issue(32'h1234_5678, 32'd4, 6'b000000, 32'h0, 1'b0);
    issue(32'h7777_7777, 32'd3,  SRL, 32'h0EEE_EEEE, 1'b1);
    issue(32'h1234_5678, 32'h8000_0004, SRL, 32'h0, 1'b0);

    // start held high: accepted at n and n+7 only.
    @(negedge clk);
    n0 = cyc;
    dataA = 32'h0000_F000; dataB = 32'd8; Signal = SRL; start = 1'b1;
    sb.push_back('{32'h0000_00F0, n0 + 6});
    sb.push_back('{32'h0000_00F0, n0 + 13});
    repeat (14) @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("held_start_busy", 32'(busy), 32'd0);

    // Mid-operation reset at n+3: abort with no done pulse.
    issue(32'h1111_0000, 32'd4, SRL, 32'h0111_1000, 1'b1);
    @(negedge clk);
    dataA = 32'hCAFE_F00D; dataB = 32'd2; Signal = SRL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    hold = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dataOut", dataOut, 32'h0);

    // start coincident with reset is ignored.
    reset = 1'b1; start = 1'b1; dataA = 32'hFFFF_0000; dataB = 32'd1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_start_busy", 32'(busy), 32'd0);

    issue(32'h8765_4321, 32'd8, SRL, 32'h0087_6543, 1'b1);
    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
